// File: rtl/flopr.sv
// flopr: resettable D flip-flop bank (PC register, pipeline/state registers).
// Define FLOPR_ASSERT_EN to compile in simulation-only input/output checks.
module flopr #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("flopr: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d;
    end

    // Reset is sampled only at the edge and wins over data.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifdef FLOPR_ASSERT_EN
    logic             chk_valid_q;
    logic             chk_reset_q;
    logic [WIDTH-1:0] chk_d_q;

    // Each edge checks the inputs now and the result of the previous edge.
    always_ff @(posedge clk) begin
        if ($isunknown(reset)) begin
            $error("flopr: reset is X/Z at a rising edge");
        end
        if (reset === 1'b0 && $isunknown(d)) begin
            $error("flopr: d is X/Z at a non-reset rising edge");
        end
        if (chk_valid_q) begin
            if (chk_reset_q && q_q !== RESET_VALUE) begin
                $error("flopr: q=%h after reset edge, expected %h", q_q, RESET_VALUE);
            end
            if (!chk_reset_q && q_q !== chk_d_q) begin
                $error("flopr: q=%h after load edge, expected %h", q_q, chk_d_q);
            end
        end
        chk_valid_q <= !$isunknown(reset) && (reset || !$isunknown(d));
        chk_reset_q <= reset;
        chk_d_q     <= d;
    end
`endif

endmodule

// File: tb/tb_flopr.sv
// tb_flopr: directed vector bench for flopr at WIDTH=32 (default reset value)
// and WIDTH=8 with RESET_VALUE=8'hA5.
module tb_flopr;

    typedef struct {
        logic        rst;
        logic [31:0] d;
        logic [31:0] exp_q;
    } vec_t;

    logic        clk;
    logic        reset32;
    logic [31:0] d32;
    logic [31:0] q32;
    logic        reset8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    int pass_cnt;
    int total_cnt;

    vec_t vec_a [3];
    vec_t vec_b [6];
    vec_t vec_c [5];

    flopr dut32 (
        .clk   (clk),
        .reset (reset32),
        .d     (d32),
        .q     (q32)
    );

    flopr #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs mid-low-phase, then sample 1 time unit after the edge.
    task automatic step32(input logic rst, input logic [31:0] d);
        @(negedge clk);
        reset32 = rst;
        d32     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic rst, input logic [7:0] d);
        @(negedge clk);
        reset8 = rst;
        d8     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input vec_t v, input string name);
        step32(v.rst, v.d);
        check(name, q32, v.exp_q);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset32   = 1'b1;
        d32       = 32'h0;
        reset8    = 1'b1;
        d8        = 8'h0;

        vec_a[0] = '{1'b1, 32'h12345678, 32'h00000000};
        vec_a[1] = '{1'b0, 32'h12345678, 32'h12345678};
        vec_a[2] = '{1'b0, 32'hABCDEF01, 32'hABCDEF01};

        vec_b[0] = '{1'b1, 32'hFFFFFFFF, 32'h00000000};
        vec_b[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000};
        vec_b[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000000};
        vec_b[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vec_b[4] = '{1'b0, 32'h80000001, 32'h80000001};
        vec_b[5] = '{1'b0, 32'h00000000, 32'h00000000};

        vec_c[0] = '{1'b1, 32'h0000003C, 32'h000000A5};
        vec_c[1] = '{1'b0, 32'h0000003C, 32'h0000003C};
        vec_c[2] = '{1'b0, 32'h000000FF, 32'h000000FF};
        vec_c[3] = '{1'b1, 32'h000000FF, 32'h000000A5};
        vec_c[4] = '{1'b0, 32'h00000000, 32'h00000000};

        for (int i = 0; i < 3; i++) begin
            run32(vec_a[i], $sformatf("load_a%0d", i));
        end

        // Data changes between edges must not reach q.
        #2 d32 = 32'h55555555;
        #2 check("hold_d_mid", q32, 32'hABCDEF01);

        // Reset raised between edges only acts at the next edge.
        #1;
        d32     = 32'hDEADBEEF;
        reset32 = 1'b1;
        #1 check("sync_reset_mid", q32, 32'hABCDEF01);
        @(posedge clk);
        #1 check("sync_reset_edge", q32, 32'h00000000);

        for (int i = 0; i < 6; i++) begin
            run32(vec_b[i], $sformatf("prio_b%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            step8(vec_c[i].rst, vec_c[i].d[7:0]);
            check($sformatf("w8_c%0d", i), {24'h0, q8}, vec_c[i].exp_q);
        end

        // The 8-bit bank ignores mid-cycle reset until the edge.
        #2 reset8 = 1'b1;
        #2 check("w8_reset_mid", {24'h0, q8}, 32'h00000000);
        @(posedge clk);
        #1 check("w8_reset_edge", {24'h0, q8}, 32'h000000A5);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
